// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-speed tester: FSM states,
// active-low seven-segment patterns, LFSR seed and BCD/segment helpers.
package reaction_pkg;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        GO    = 2'd1,
        DONE  = 2'd2,
        EARLY = 2'd3
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_OFF;
        endcase
    endfunction

    // Four-digit BCD increment that saturates at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        if (value == 16'h9999) return value;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (value[i*4 +: 4] == 4'd9) begin
                    result[i*4 +: 4] = 4'd0;
                end else begin
                    result[i*4 +: 4] = value[i*4 +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/reaction_speed_tester_seg7_scan.sv
// Four-digit multiplexed seven-segment driver; outputs are registered so the
// anode, segment and point lines always change together.
module seg7_scan
    import reaction_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic            sysclk,
    input  logic            reset,
    input  logic [3:0][3:0] digits,
    input  logic            dash,
    output logic [3:0]      AN,
    output logic [6:0]      leds,
    output logic            point
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic [1:0]    sel;
    logic          advance;

    assign advance = (div_cnt == DW'(SCAN_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            sel     <= 2'd0;
        end else begin
            div_cnt <= advance ? '0 : div_cnt + DW'(1);
            if (advance) sel <= sel + 2'd1;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            AN    <= 4'b1110;
            leds  <= SEG_0;
            point <= 1'b1;
        end else begin
            AN    <= ~(4'b0001 << sel);
            leds  <= dash ? SEG_DASH : seg_decode(digits[sel]);
            point <= (sel != 2'd3);
        end
    end

endmodule

// File: rtl/reaction_speed_tester.sv
// Reaction-time tester top: press capture, tick prescaler, FSM, BCD counter.
// Define RANDOM_DELAY_EN to add a pseudo-random 0..1023 tick extension to the wait.
module reaction_speed_tester
    import reaction_pkg::*;
#(
    parameter int TICK_DIV   = 100000,
    parameter int WAIT_TICKS = 2000,
    parameter int SCAN_DIV   = 100000
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       press,
    output logic       LED,
    output logic [3:0] AN,
    output logic [6:0] leds,
    output logic       point
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WW = $clog2(WAIT_TICKS + 1025);

    state_t        state, state_next;
    logic          enter_wait;
    logic          press_flag, flag_clr, consume_q;
    logic          sync1, sync2, sync3, press_evt;
    logic [TW-1:0] pre_cnt;
    logic          tick;
    logic [WW-1:0] wait_cnt, wait_target;
    logic [15:0]   count;

    // The flag is clocked by the button itself so nanosecond pulses are not
    // missed; a registered consume pulse clears it once the FSM has acted.
    assign flag_clr = reset | consume_q;

    always_ff @(posedge press or posedge flag_clr) begin
        if (flag_clr) press_flag <= 1'b0;
        else          press_flag <= 1'b1;
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            consume_q <= 1'b0;
        end else begin
            sync1     <= press_flag;
            sync2     <= sync1;
            sync3     <= sync2;
            consume_q <= press_evt;
        end
    end

    // Edge detect keeps the trailing high of the synchronizer from counting twice.
    assign press_evt  = sync2 & ~sync3;
    assign enter_wait = (state_next == WAIT) && (state != WAIT);
    assign tick       = (pre_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset)                    pre_cnt <= '0;
        else if (enter_wait || tick)  pre_cnt <= '0;
        else                          pre_cnt <= pre_cnt + TW'(1);
    end

`ifdef RANDOM_DELAY_EN
    logic [15:0] lfsr;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset)           wait_target <= WW'(WAIT_TICKS) + WW'(LFSR_SEED[9:0]);
        else if (enter_wait) wait_target <= WW'(WAIT_TICKS) + WW'(lfsr[9:0]);
    end
`else
    assign wait_target = WW'(WAIT_TICKS);
`endif

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (enter_wait)
            wait_cnt <= '0;
        else if (state == WAIT && tick && wait_cnt != wait_target)
            wait_cnt <= wait_cnt + WW'(1);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) state <= WAIT;
        else       state <= state_next;
    end

    // NOTE: next state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            WAIT: begin
                if (press_evt)                    state_next = EARLY;
                else if (wait_cnt == wait_target) state_next = GO;
            end
            GO:      if (press_evt) state_next = DONE;
            DONE:    if (press_evt) state_next = WAIT;
            EARLY:   if (press_evt) state_next = WAIT;
            default: state_next = WAIT;
        endcase
    end

    // A tick in the same cycle as the freezing press still counts.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset)                    count <= 16'h0000;
        else if (enter_wait)          count <= 16'h0000;
        else if (state == GO && tick) count <= bcd_inc(count);
    end

    assign LED = (state == GO);

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .sysclk (sysclk),
        .reset  (reset),
        .digits (count),
        .dash   (state == EARLY),
        .AN     (AN),
        .leds   (leds),
        .point  (point)
    );

endmodule

// File: tb/tb_reaction_speed_tester.sv
// Directed bench for reaction_speed_tester (TICK_DIV=10, WAIT_TICKS=100, SCAN_DIV=4)
// plus a fast-ticking second instance that exercises 9999 saturation.
`timescale 1ns/100ps
module tb_reaction_speed_tester;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b0;
    logic       press  = 1'b0;
    logic       rst_s  = 1'b0;
    logic       press_s = 1'b0;
    logic       LED, point, LED_s, point_s;
    logic [3:0] AN, AN_s;
    logic [6:0] leds, leds_s;

    logic       mon_sat = 1'b0;
    logic [3:0] an_m;
    logic [6:0] leds_m;
    logic       point_m;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int r0, r1, c0, c1, rise;

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    reaction_speed_tester #(
        .TICK_DIV (10), .WAIT_TICKS (100), .SCAN_DIV (4)
    ) dut (
        .sysclk (sysclk), .reset (reset), .press (press),
        .LED (LED), .AN (AN), .leds (leds), .point (point)
    );

    reaction_speed_tester #(
        .TICK_DIV (1), .WAIT_TICKS (4), .SCAN_DIV (2)
    ) dut_sat (
        .sysclk (sysclk), .reset (rst_s), .press (press_s),
        .LED (LED_s), .AN (AN_s), .leds (leds_s), .point (point_s)
    );

    assign an_m    = mon_sat ? AN_s    : AN;
    assign leds_m  = mon_sat ? leds_s  : leds;
    assign point_m = mon_sat ? point_s : point;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge sysclk);
    endtask

    task automatic wait_led(input string tag, input logic val, input int budget);
        int n;
        n = 0;
        while (LED !== val && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        check(tag, LED, val);
    endtask

    // Walk the scan through all four digit positions and check each one.
    task automatic scan_expect(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                               input logic [6:0] d1, input logic [6:0] d0);
        logic [6:0] exp_seg [4];
        logic [3:0] an_exp;
        int         n;
        exp_seg[0] = d0; exp_seg[1] = d1; exp_seg[2] = d2; exp_seg[3] = d3;
        for (int k = 0; k < 4; k++) begin
            an_exp = ~(4'b0001 << k);
            n = 0;
            while (an_m !== an_exp && n < 64) begin
                @(negedge sysclk);
                n++;
            end
            check($sformatf("%s_an%0d", tag, k), an_m, an_exp);
            check($sformatf("%s_seg%0d", tag, k), leds_m, exp_seg[k]);
            check($sformatf("%s_dp%0d", tag, k), point_m, (k == 3) ? 1'b0 : 1'b1);
        end
    endtask

    initial begin
        #100 reset = 1'b1; rst_s = 1'b1;
        #1   reset = 1'b0; rst_s = 1'b0;
        r0 = cyc;
        #1;
        check("rst_led",   LED,   1'b0);
        check("rst_an",    AN,    4'b1110);
        check("rst_leds",  leds,  S0);
        check("rst_point", point, 1'b1);

        // Go light: 100 ticks of 10 cycles from reset.
        wait_cyc(r0 + 999);
        check("go_low", LED, 1'b0);
        wait_cyc(r0 + 1001);
        check("go_high", LED, 1'b1);

        // Press at 20.1 us: ticks land every 10 cycles in GO, 100 of them so far.
        wait_cyc(r0 + 2000);
        press = 1'b1; #1 press = 1'b0;
        repeat (3) @(negedge sysclk);
        check("react_led", LED, 1'b0);
        scan_expect("react", S0, S1, S0, S0);

        // Restart from DONE.
        @(negedge sysclk);
        c0 = cyc;
        #2 press = 1'b1; #1 press = 1'b0;
        wait_cyc(c0 + 8);
        scan_expect("restart", S0, S0, S0, S0);
        wait_cyc(c0 + 1002);
        check("restart_low", LED, 1'b0);
        wait_led("restart_go", 1'b1, 5);
        rise = cyc;

        // Held press: ticks at rise+9 and rise+19 only, then frozen at 0002.
        wait_cyc(rise + 25);
        press = 1'b1;
        wait_cyc(rise + 85);
        check("hold_led", LED, 1'b0);
        scan_expect("hold", S0, S0, S0, S2);
        press = 1'b0;
        repeat (5) @(negedge sysclk);
        c1 = cyc;
        #2 press = 1'b1; #1 press = 1'b0;
        wait_cyc(c1 + 8);
        scan_expect("rearm", S0, S0, S0, S0);
        check("rearm_led", LED, 1'b0);

        // Early press 500 cycles after reset.
        @(negedge sysclk);
        #2 reset = 1'b1; #1 reset = 1'b0;
        r1 = cyc;
        wait_cyc(r1 + 500);
        #2 press = 1'b1; #1 press = 1'b0;
        wait_cyc(r1 + 506);
        check("early_led", LED, 1'b0);
        scan_expect("early", SD, SD, SD, SD);
        wait_cyc(r1 + 1500);
        check("early_hold", LED, 1'b0);

        // Back to WAIT, then reset asynchronously while in GO.
        @(negedge sysclk);
        #2 press = 1'b1; #1 press = 1'b0;
        wait_led("rego", 1'b1, 1100);
        @(negedge sysclk);
        #2 reset = 1'b1;
        #0.9;
        check("arst_led",   LED,   1'b0);
        check("arst_an",    AN,    4'b1110);
        check("arst_leds",  leds,  S0);
        check("arst_point", point, 1'b1);
        #0.1 reset = 1'b0;
        repeat (20) @(negedge sysclk);
        check("arst_after", LED, 1'b0);

        // Fast instance: would pass 9999 near cycle 10013 without saturation.
        wait_cyc(10300);
        mon_sat = 1'b1;
        scan_expect("sat", S9, S9, S9, S9);
        check("sat_led", LED_s, 1'b1);
        wait_cyc(10500);
        scan_expect("sat2", S9, S9, S9, S9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
